// File: rtl/pio_irq_pkg.sv
// Shared definitions for the parallel-input interrupt port: register map and arming states.
package pio_irq_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd4;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } arm_state_t;

    // Bits needed for a counter that must reach n.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Per-bit synchroniser chain followed by rising/falling edge detection on the synchronised value.
module pio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s = r_sync[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign rise[gi] =  s[gi] & ~r_prev[gi];
            assign fall[gi] = ~s[gi] &  r_prev[gi];
        end
    endgenerate

endmodule

// File: rtl/pio_irq_in.sv
// Avalon-MM parallel input port with selectable edge capture, write-1-to-clear
// capture bits and a maskable level interrupt.
module pio_irq_in
    import pio_irq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RISE_RESET  = '1,
    parameter logic [WIDTH-1:0] FALL_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = count_width(SYNC_STAGES);

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .s       (w_s),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // Arming: hold off capture until the synchroniser has been refilled after reset.
    arm_state_t      r_state;
    arm_state_t      w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            w_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WARM;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            WARM: begin
                if (r_count == CW'(SYNC_STAGES)) begin
                    w_state_next = RUN;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = WARM;
        endcase
    end

    assign w_armed = (r_state == RUN);

    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_capture;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_hit;
    logic [31:0]      w_rd_mux;

    assign w_wr    = chipselect && !write_n;
    assign w_wdata = writedata[WIDTH-1:0];
    assign w_w1c   = (w_wr && (address == ADDR_CAPTURE)) ? w_wdata : '0;
    assign w_hit   = {WIDTH{w_armed}} & ((w_rise & r_rise_en) | (w_fall & r_fall_en));

    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic w_unused_wdata;
            assign w_unused_wdata = &{1'b0, writedata[31:WIDTH]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rise_en  <= RISE_RESET;
            r_fall_en  <= FALL_RESET;
            r_irq_mask <= '0;
            r_capture  <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr && (address == ADDR_RISE_EN))  r_rise_en  <= w_wdata;
            if (w_wr && (address == ADDR_FALL_EN))  r_fall_en  <= w_wdata;
            if (w_wr && (address == ADDR_IRQ_MASK)) r_irq_mask <= w_wdata;
            // A new hit outranks a simultaneous clear of the same bit.
            r_capture  <= (r_capture & ~w_w1c) | w_hit;
            r_readdata <= w_rd_mux;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_s;
            ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0] = r_rise_en;
            ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0] = r_fall_en;
            ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_CAPTURE:  w_rd_mux[WIDTH-1:0] = r_capture;
            default:       w_rd_mux = '0;
        endcase
    end

    assign readdata = r_readdata;
    assign irq      = |(r_capture & r_irq_mask);

endmodule
